wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised write-back stage for the pipelined RISC-V core, generalising the combinational write-back select into a registered stage. It accepts one retiring instruction per cycle from MEM, picks the register-file write value (PC+4, compare-extend result, ALU result or load data), and aligns and sign- or zero-extends load data. It waits, with a timeout, for variable-latency data-memory responses, and drives the register-file write port and an optional forwarding port.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- REG_AW, 5: register address width.
- MEM_TIMEOUT, 15: maximum cycles spent waiting for `mem_rvalid`; range 1..255.
- clk  in  1  core clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  MEM presents an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_pc4 / in_comp / in_alu  in  XLEN  candidate write values.
- in_rwsel  in  2  source select, using the shared REGWD_* encodings (PC, COMPOUT, ALUOUT, DRAM).
- in_we  in  1  instruction writes a register.
- in_rd  in  REG_AW  destination register.
- in_ld_size  in  2  00 byte, 01 half, 10 word, 11 double.
- in_ld_unsigned  in  1  zero-extend load.
- in_addr_lo  in  log2(XLEN/8)  byte offset of load address.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  raw aligned-word load data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  XLEN  write data.
- ld_timeout  out  1  one-cycle pulse: load abandoned.
- fwd_valid / fwd_rd / fwd_data  out  1 / REG_AW / XLEN  forwarding port; present only with WB_FWD_EN.

## Operation
- The FSM has two states: IDLE and WAIT_MEM.
- `in_ready` = 1 only in IDLE. A transfer occurs when `in_valid & in_ready`.
- IDLE, non-DRAM transfer: register the selected value. Next cycle, `rf_we` = `in_we & (in_rd != 0)`. The FSM stays in IDLE.
- IDLE, DRAM transfer: latch rd, we, size, unsigned and offset. Go to WAIT_MEM and clear the wait counter.
- WAIT_MEM, on `mem_rvalid`:
  - Extract the field at byte offset `in_addr_lo` (size in bytes).
  - Sign- or zero-extend it to XLEN.
  - Register the result. Next cycle, `rf_we` follows the same rule as above. Return to IDLE.
- Size 11 with XLEN=32 is treated as word.
- Misaligned fields wrap within the word: byte index is taken modulo XLEN/8.
- WAIT_MEM without `mem_rvalid`: increment the counter. When the counter reaches MEM_TIMEOUT, pulse `ld_timeout`, suppress the write and return to IDLE.
- If `mem_rvalid` arrives in the same cycle the counter reaches MEM_TIMEOUT, the data wins and no timeout is raised.
- `mem_rvalid` while in IDLE is ignored.
- Reset (`rst_n` = 0 at an edge): FSM → IDLE, counter = 0, any pending load is dropped.
- Reset values: `rf_we`, `rf_waddr`, `rf_wdata`, `ld_timeout`, `fwd_*` all 0. `in_ready` = 1 from the first cycle after reset.

## Timing
- Non-load latency: accept at edge N → `rf_we` high during cycle N+1. Throughput is 1 per cycle.
- Load latency: `mem_rvalid` sampled at edge M → `rf_we` high during cycle M+1. `in_ready` rises in that same cycle M+1.
- `rf_we` is a single-cycle pulse per retired instruction.
- `ld_timeout` is asserted during the cycle after the timing-out edge.

## Configuration
- WB_FWD_EN defined:
  - `fwd_valid`/`fwd_rd`/`fwd_data` are present.
  - They combinationally mirror the value about to be registered: on a non-DRAM transfer, or in WAIT_MEM with `mem_rvalid`, with the same rd≠0 and we gating. This lets EX bypass one cycle early.
- WB_FWD_EN undefined: the ports and that logic are omitted. Hazards are resolved by stalling upstream.

## Structure
- Shared package/header holds the REGWD_* select encodings, LDSZ_* size encodings and the FSM state constants.
- One natural sub-module: `ld_extend`. It is purely combinational (rdata, offset, size, unsigned → XLEN) and is reused by the forwarding path.

## Test plan
- ALU write, XLEN=32: rwsel=ALUOUT, alu=0x1234_5678, rd=5, we=1 → next cycle `rf_we`=1, waddr=5, wdata=0x1234_5678.
- rd=0: rwsel=PC, pc4=0x100 → `rf_we` stays 0 and `in_ready` stays 1.
- Signed byte load: size=00, offset=3, rdata=0x80AA_BBCC, `mem_rvalid` 2 cycles after accept → wdata=0xFFFF_FF80. `in_ready` is 0 during the wait.
- Unsigned half load: offset=2, rdata=0x8001_0000 → wdata=0x0000_8001. Same load with XLEN=64, size=11 → full 64-bit rdata is written.
- Timeout: MEM_TIMEOUT=4, no `mem_rvalid` → one `ld_timeout` pulse, no `rf_we`, back to IDLE. Variant: `mem_rvalid` on the 4th wait cycle → write occurs, no timeout.
- Reset mid-load: assert `rst_n`=0 in WAIT_MEM → all outputs 0 next cycle. A late `mem_rvalid` produces no write.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared encodings for the write-back stage.
//   REGWD_* : register-file write source select
//   LDSZ_*  : load size select
//   wb_state_e : write-back FSM states
package wb_stage_pkg;
    localparam logic [1:0] REGWD_PC      = 2'd0;
    localparam logic [1:0] REGWD_COMPOUT = 2'd1;
    localparam logic [1:0] REGWD_ALUOUT  = 2'd2;
    localparam logic [1:0] REGWD_DRAM    = 2'd3;
    localparam logic [1:0] LDSZ_B = 2'd0;
    localparam logic [1:0] LDSZ_H = 2'd1;
    localparam logic [1:0] LDSZ_W = 2'd2;
    localparam logic [1:0] LDSZ_D = 2'd3;
    typedef enum logic {S_IDLE = 1'b0, S_WAIT_MEM = 1'b1} wb_state_e;
endpackage

// File: rtl/wb_stage_ld_extend.sv
// wb_stage_ld_extend: combinational load field extraction and sign/zero extension.
//   rdata_i : raw aligned-word load data
//   off_i   : byte offset of the load inside the word
//   size_i  : LDSZ_* load size (double on a 32-bit datapath acts as word)
//   uns_i   : zero-extend when set
//   data_o  : extended XLEN result
module wb_stage_ld_extend
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [OFFW-1:0] off_i,
    input  logic [1:0]      size_i,
    input  logic            uns_i,
    output logic [XLEN-1:0] data_o
);
    logic [2*XLEN-1:0] rot;
    logic [XLEN-1:0]   f;
    logic              sgn;
    int                nbits;
    always_comb begin
        // Rotating the doubled word makes misaligned fields wrap within the word.
        rot   = {rdata_i, rdata_i} >> {off_i, 3'b000};
        f     = rot[XLEN-1:0];
        nbits = size_i == LDSZ_B ? 8 : size_i == LDSZ_H ? 16 : size_i == LDSZ_W ? 32 : XLEN;
        sgn   = ~uns_i & (size_i == LDSZ_B ? f[7] : size_i == LDSZ_H ? f[15] :
                          size_i == LDSZ_W ? f[31] : f[XLEN-1]);
        for (int i = 0; i < XLEN; i++) data_o[i] = i < nbits ? f[i] : sgn;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered write-back stage with load alignment and memory-response timeout.
//   in_*        : retiring instruction from MEM (in_ready high only when idle)
//   mem_rvalid/mem_rdata : variable-latency load response
//   rf_we/rf_waddr/rf_wdata : register-file write port (one-cycle write pulse)
//   ld_timeout  : one-cycle pulse when a load is abandoned
//   fwd_*       : early forwarding port, present only when WB_FWD_EN is defined
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    localparam int OFFW       = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic [XLEN-1:0]   in_comp,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [1:0]        in_rwsel,
    input  logic              in_we,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [OFFW-1:0]   in_addr_lo,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
`ifdef WB_FWD_EN
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output logic              ld_timeout
);
    wb_state_e         state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              we_q, we_d, uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              rf_we_q, rf_we_d, to_q, to_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [XLEN-1:0]   sel_val, ld_val, c_data;
    logic [REG_AW-1:0] c_rd;
    logic              commit, c_we;

    assign in_ready   = state_q == S_IDLE;
    assign sel_val    = in_rwsel == REGWD_PC ? in_pc4 : in_rwsel == REGWD_COMPOUT ? in_comp : in_alu;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign ld_timeout = to_q;

    wb_stage_ld_extend #(.XLEN(XLEN), .OFFW(OFFW)) u_ext (
        .rdata_i (mem_rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (ld_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        to_d    = 1'b0;
        commit  = 1'b0;
        c_rd    = rd_q;
        c_we    = we_q;
        c_data  = ld_val;
        if (state_q == S_IDLE) begin
            if (in_valid && in_rwsel != REGWD_DRAM) begin
                commit = 1'b1;
                c_rd   = in_rd;
                c_we   = in_we;
                c_data = sel_val;
            end else if (in_valid) begin
                state_d = S_WAIT_MEM;
                cnt_d   = '0;
                rd_d    = in_rd;
                we_d    = in_we;
                size_d  = in_ld_size;
                uns_d   = in_ld_unsigned;
                off_d   = in_addr_lo;
            end
        end else if (mem_rvalid) begin
            // Data arriving on the last permitted wait cycle still wins.
            commit  = 1'b1;
            state_d = S_IDLE;
        end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        rf_we_d    = commit & c_we & (c_rd != '0);
        rf_waddr_d = commit ? c_rd : rf_waddr_q;
        rf_wdata_d = commit ? c_data : rf_wdata_q;
    end

`ifdef WB_FWD_EN
    // Mirrors the value about to be registered so EX can bypass a cycle early.
    assign fwd_valid = rst_n & rf_we_d;
    assign fwd_rd    = fwd_valid ? c_rd : '0;
    assign fwd_data  = fwd_valid ? c_data : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            to_q       <= to_d;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized self-checking bench for wb_stage, 32- and 64-bit instances in lockstep.
module tb_wb_stage;
    localparam int T = 4;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, we, uns, rvalid;
    logic [63:0] pc4, comp, alu, rdata;
    logic [1:0]  rwsel, size;
    logic [4:0]  rd;
    logic [2:0]  off;
    logic        r32_ready, r32_we, r32_to, r64_ready, r64_we, r64_to;
    logic [4:0]  r32_waddr, r64_waddr;
    logic [31:0] r32_wdata;
    logic [63:0] r64_wdata;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .REG_AW(5), .MEM_TIMEOUT(T)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32_ready),
        .in_pc4(pc4[31:0]), .in_comp(comp[31:0]), .in_alu(alu[31:0]), .in_rwsel(rwsel),
        .in_we(we), .in_rd(rd), .in_ld_size(size), .in_ld_unsigned(uns), .in_addr_lo(off[1:0]),
        .mem_rvalid(rvalid), .mem_rdata(rdata[31:0]), .rf_we(r32_we), .rf_waddr(r32_waddr),
        .rf_wdata(r32_wdata), .ld_timeout(r32_to)
    );

    wb_stage #(.XLEN(64), .REG_AW(5), .MEM_TIMEOUT(T)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64_ready),
        .in_pc4(pc4), .in_comp(comp), .in_alu(alu), .in_rwsel(rwsel),
        .in_we(we), .in_rd(rd), .in_ld_size(size), .in_ld_unsigned(uns), .in_addr_lo(off),
        .mem_rvalid(rvalid), .mem_rdata(rdata), .rf_we(r64_we), .rf_waddr(r64_waddr),
        .rf_wdata(r64_wdata), .ld_timeout(r64_to)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit go = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    endtask

    // Load result from byte-level rules: gather bytes (wrapping in the word), then extend.
    function automatic logic [63:0] m_ext(input logic [63:0] d, input int xl, input int o,
                                         input int sz, input bit u);
        int nb = xl / 8;
        int n = sz == 3 ? nb : (1 << sz);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*((o + i) % nb) +: 8];
        if (!u && v[8*n-1]) for (int b = 8 * n; b < xl; b++) v[b] = 1'b1;
        return v;
    endfunction

    // Reference: a pending load either retires on the first valid response or is
    // abandoned on the edge MEM_TIMEOUT cycles after it was accepted.
    int          xl[2] = '{32, 64};
    bit          busy[2], exp_ready[2], exp_we[2], exp_to[2], exp_zero[2];
    int          deadline[2];
    logic [4:0]  exp_waddr[2], l_rd;
    logic [63:0] exp_wdata[2];
    logic        l_we, l_uns;
    logic [1:0]  l_size;
    logic [2:0]  l_off;

    task automatic model_edge();
        logic [63:0] mask, sel;
        cyc++;
        sel = rwsel == 2'd0 ? pc4 : rwsel == 2'd1 ? comp : alu;
        for (int k = 0; k < 2; k++) begin
            mask = k == 0 ? 64'hFFFF_FFFF : '1;
            exp_we[k] = 1'b0;
            exp_to[k] = 1'b0;
            exp_zero[k] = 1'b0;
            if (!rst_n) begin
                busy[k] = 1'b0;
                exp_zero[k] = 1'b1;
                exp_waddr[k] = '0;
                exp_wdata[k] = '0;
            end else if (!busy[k]) begin
                if (in_valid && rwsel == 2'd3) begin
                    busy[k] = 1'b1;
                    deadline[k] = cyc + T;
                    l_rd = rd; l_we = we; l_size = size; l_uns = uns; l_off = off;
                end else if (in_valid) begin
                    exp_we[k] = we && rd != 0;
                    exp_waddr[k] = rd;
                    exp_wdata[k] = sel & mask;
                end
            end else if (rvalid) begin
                busy[k] = 1'b0;
                exp_we[k] = l_we && l_rd != 0;
                exp_waddr[k] = l_rd;
                exp_wdata[k] = m_ext(rdata & mask, xl[k], int'(l_off) % (xl[k] / 8), int'(l_size), l_uns);
            end else if (cyc == deadline[k]) begin
                busy[k] = 1'b0;
                exp_to[k] = 1'b1;
            end
            exp_ready[k] = !busy[k];
        end
    endtask

    always @(negedge clk) if (go) begin
        chk("ready32", 64'(r32_ready), 64'(exp_ready[0]));
        chk("we32", 64'(r32_we), 64'(exp_we[0]));
        chk("timeout32", 64'(r32_to), 64'(exp_to[0]));
        if (exp_we[0] || exp_zero[0]) begin
            chk("waddr32", 64'(r32_waddr), 64'(exp_waddr[0]));
            chk("wdata32", 64'(r32_wdata), exp_wdata[0]);
        end
        chk("ready64", 64'(r64_ready), 64'(exp_ready[1]));
        chk("we64", 64'(r64_we), 64'(exp_we[1]));
        chk("timeout64", 64'(r64_to), 64'(exp_to[1]));
        if (exp_we[1] || exp_zero[1]) begin
            chk("waddr64", 64'(r64_waddr), 64'(exp_waddr[1]));
            chk("wdata64", r64_wdata, exp_wdata[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        go = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sz, input logic [2:0] o, input bit u, input logic [4:0] r);
        in_valid = 1'b1; rwsel = 2'd3; size = sz; off = o; uns = u; rd = r; we = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; we = 1'b0; uns = 1'b0; rvalid = 1'b0;
        pc4 = '0; comp = '0; alu = '0; rdata = '0; rwsel = '0; size = '0; rd = '0; off = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("lit_reset_ready", 64'(r32_ready), 64'd1);
        chk("lit_reset_wdata", 64'(r32_wdata), 64'd0);
        // ALU write
        in_valid = 1'b1; rwsel = 2'd2; alu = 64'h1234_5678; rd = 5'd5; we = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lit_alu_we", 64'(r32_we), 64'd1);
        chk("lit_alu_waddr", 64'(r32_waddr), 64'd5);
        chk("lit_alu_wdata", 64'(r32_wdata), 64'h1234_5678);
        // rd = 0 never writes
        in_valid = 1'b1; rwsel = 2'd0; pc4 = 64'h100; rd = 5'd0;
        tick();
        in_valid = 1'b0;
        chk("lit_rd0_we", 64'(r32_we), 64'd0);
        chk("lit_rd0_ready", 64'(r32_ready), 64'd1);
        // signed byte at offset 3, response two cycles after accept
        load(2'd0, 3'd3, 1'b0, 5'd7);
        chk("lit_sb_wait_ready", 64'(r32_ready), 64'd0);
        tick();
        rvalid = 1'b1; rdata = 64'h80AA_BBCC;
        tick();
        rvalid = 1'b0;
        chk("lit_sb_wdata32", 64'(r32_wdata), 64'hFFFF_FF80);
        chk("lit_sb_wdata64", r64_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lit_sb_ready", 64'(r32_ready), 64'd1);
        // unsigned half at offset 2
        load(2'd1, 3'd2, 1'b1, 5'd8);
        rvalid = 1'b1; rdata = 64'h8001_0000;
        tick();
        rvalid = 1'b0;
        chk("lit_uh_wdata32", 64'(r32_wdata), 64'h0000_8001);
        chk("lit_uh_wdata64", r64_wdata, 64'h0000_8001);
        // double: full word on 64-bit, treated as word on 32-bit
        load(2'd3, 3'd0, 1'b1, 5'd9);
        rvalid = 1'b1; rdata = 64'hDEAD_BEEF_8001_0000;
        tick();
        rvalid = 1'b0;
        chk("lit_dw_wdata32", 64'(r32_wdata), 64'h8001_0000);
        chk("lit_dw_wdata64", r64_wdata, 64'hDEAD_BEEF_8001_0000);
        // timeout with no response
        load(2'd2, 3'd0, 1'b0, 5'd10);
        tick(); tick(); tick();
        chk("lit_to_not_yet", 64'(r32_to), 64'd0);
        tick();
        chk("lit_to_pulse", 64'(r32_to), 64'd1);
        chk("lit_to_no_we", 64'(r32_we), 64'd0);
        chk("lit_to_ready", 64'(r32_ready), 64'd1);
        tick();
        chk("lit_to_single", 64'(r32_to), 64'd0);
        // response on the last permitted wait cycle wins
        load(2'd2, 3'd0, 1'b0, 5'd11);
        tick(); tick(); tick();
        rvalid = 1'b1; rdata = 64'h1122_3344;
        tick();
        rvalid = 1'b0;
        chk("lit_late_we", 64'(r32_we), 64'd1);
        chk("lit_late_to", 64'(r32_to), 64'd0);
        chk("lit_late_wdata", 64'(r32_wdata), 64'h1122_3344);
        // reset while waiting drops the load
        load(2'd2, 3'd0, 1'b0, 5'd12);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("lit_rst_we", 64'(r32_we), 64'd0);
        chk("lit_rst_wdata", 64'(r32_wdata), 64'd0);
        chk("lit_rst_ready", 64'(r32_ready), 64'd1);
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("lit_rst_late", 64'(r32_we), 64'd0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n    = $urandom_range(0, 99) != 0;
            in_valid = $urandom_range(0, 2) != 0;
            rwsel    = $urandom_range(0, 9) < 4 ? 2'd3 : 2'($urandom_range(0, 2));
            we       = $urandom_range(0, 4) != 0;
            rd       = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            size     = 2'($urandom);
            uns      = 1'($urandom);
            off      = 3'($urandom);
            rvalid   = $urandom_range(0, 9) < 3;
            pc4      = {$urandom, $urandom};
            comp     = {$urandom, $urandom};
            alu      = {$urandom, $urandom};
            rdata    = {$urandom, $urandom};
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
